rr_onehot_arbiter: RTL
======================

// Module: rr_onehot_arbiter
// PURPOSE
//  Round-robin arbiter granting one shared resource to REQ_N requesters.
//  Priority search is a rightmost-set-bit scan (one-hot result, same function
//  as the outer-ones finder) over a rotated request mask.
//  Holds each grant until release or timeout.
//  Sits in front of any single-port datapath shared by several masters.
// PARAMETERS
//  REQ_N     4   number of requesters; >=2
//  HOLD_MAX  8   max consecutive grant cycles per owner; 0 = no timeout
//  IDX_W     $clog2(REQ_N)  width of grant index (derived, do not override)
// PORTS
//  clk_i      in   1      clock, all state on rising edge
//  rst_i      in   1      asynchronous reset, active-high
//  req_i      in   REQ_N  request vector, bit k = requester k
//  gnt_o      out  REQ_N  one-hot grant, registered
//  gnt_val_o  out  1      any grant active (== |gnt_o)
//  gnt_idx_o  out  IDX_W  binary index of granted requester, valid when gnt_val_o
//  tmo_o      out  1      one-cycle pulse: current grant was forcibly revoked
// BEHAVIOUR
//  Reset: gnt_o=0, gnt_val_o=0, gnt_idx_o=0, tmo_o=0, state IDLE, ptr=0, hold_cnt=0.
//  States: IDLE -> BUSY on arbitration win; BUSY -> IDLE on release/timeout.
//  IDLE, cycle t: if |req_i, winner = lowest set index k with k>=ptr (masked scan);
//   if none, lowest set index overall (wrap). gnt_o=1<<k from cycle t+1. req_i==0: stay IDLE.
//  BUSY: grant held while req_i[owner]=1; other req_i bits ignored.
//  Release: req_i[owner]=0 at cycle t -> gnt_o=0 at t+1, state IDLE.
//   Next grant earliest at t+2 (exactly one bubble cycle, always).
//  ptr update on every grant end (release or timeout): ptr = owner+1, wraps REQ_N-1 -> 0.
//  Timeout (HOLD_MAX>0): hold_cnt counts grant cycles from 1.
//   When hold_cnt==HOLD_MAX and req_i[owner] still 1: gnt_o=0 next cycle, tmo_o=1 for
//   that same one cycle, state IDLE. Same requester may win again if it is alone.
//  Release and timeout in same cycle: treat as release, tmo_o stays 0.
//  hold_cnt saturates, never wraps; cleared on entry to IDLE.
//  Reset asserted mid-grant: all outputs to reset values immediately (async); ptr=0.
//  gnt_o never has more than one bit set; gnt_o!=0 implies req_i[owner] was 1
//   on the cycle the grant was issued.
// STRUCTURE
//  Package rr_arb_pkg: typedef enum logic {IDLE, BUSY} arb_state_t;
//   function onehot2idx; localparam defaults REQ_N_DEF=4, HOLD_MAX_DEF=8.
//  Sub-module first1_finder #(W): combinational, in [W-1:0] -> one-hot rightmost
//   set bit + found flag. Instantiated twice (masked mask, unmasked mask).
//  Top: state reg, ptr reg, hold_cnt reg, grant reg, mask generation, tmo pulse.
// TESTING (REQ_N=4, HOLD_MAX=8 unless noted)
//  1 reset, req_i=0 for 5 cycles -> gnt_o=0000, gnt_val_o=0, tmo_o=0 throughout.
//  2 req_i=1111 held, each owner drops req 3 cycles after its grant then re-raises
//    -> grants 0001,0010,0100,1000,0001 in order, one idle cycle between each.
//  3 req_i=0100 only, held 20 cycles -> gnt_o=0100 for 8 cycles, tmo_o pulse,
//    1 bubble, re-grant 0100.
//  4 HOLD_MAX=0, req_i=0010 held 50 cycles -> grant never drops, tmo_o never 1.
//  5 owner 2 granted, req_i=1011 (owner drops) -> after bubble gnt_o=1000
//    (ptr=3), not 0001.
//  6 rst_i pulsed while gnt_o=0100 -> gnt_o=0000 without waiting for clock edge;
//    after release req_i=0101 -> gnt_o=0001 (ptr reset to 0).
//  Bench checks one-hot/idx consistency every cycle against a reference model.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin one-hot arbiter.
// Provides the arbiter state enum, default parameters and onehot2idx.
package rr_arb_pkg;

    typedef enum logic {
        IDLE,
        BUSY
    } arb_state_t;

    localparam int REQ_N_DEF    = 4;
    localparam int HOLD_MAX_DEF = 8;

    // Binary index of a one-hot vector of up to 32 bits.
    // A zero vector maps to index 0.
    function automatic logic [31:0] onehot2idx(
        input logic [31:0] oh
    );
        logic [31:0] idx;
        idx = '0;
        for (int k = 0; k < 32; k++) begin
            if (oh[k]) begin
                idx = idx | 32'(k);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/first1_finder.sv
// Rightmost-set-bit finder: isolates the lowest set bit as one-hot.
// Ports: vec_i (input vector), oh_o (one-hot result), found_o (|vec_i).
module first1_finder
    import rr_arb_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] vec_i,
    output logic [W-1:0] oh_o,
    output logic         found_o
);

    // Two's complement trick: v & -v keeps only the lowest set bit.
    assign oh_o    = vec_i & (~vec_i + W'(1));
    assign found_o = |vec_i;

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with grant hold, release bubble and hold timeout.
// Ports: clk_i, rst_i, req_i -> gnt_o, gnt_val_o, gnt_idx_o, tmo_o.
module rr_onehot_arbiter
    import rr_arb_pkg::*;
#(
    parameter int REQ_N    = REQ_N_DEF,
    parameter int HOLD_MAX = HOLD_MAX_DEF,
    parameter int IDX_W    = $clog2(REQ_N)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [REQ_N-1:0] req_i,
    output logic [REQ_N-1:0] gnt_o,
    output logic             gnt_val_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             tmo_o
);

    localparam int CNT_W =
        (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;
    localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(HOLD_MAX);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(REQ_N - 1);
    localparam bit               TMO_EN   = (HOLD_MAX > 0);

    arb_state_t       state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [REQ_N-1:0] gnt_q;
    logic [IDX_W-1:0] idx_q;
    logic             tmo_q;

    logic [REQ_N-1:0] mask;
    logic [REQ_N-1:0] req_masked;
    logic [REQ_N-1:0] oh_m;
    logic [REQ_N-1:0] oh_u;
    logic             found_m;
    logic             found_u;
    logic [REQ_N-1:0] win_oh;
    logic [IDX_W-1:0] win_idx;
    logic             owner_req;
    logic             hit_top;
    logic [IDX_W-1:0] ptr_next;

    // Keep only requesters at or above the pointer.
    always_comb begin
        mask = '0;
        for (int k = 0; k < REQ_N; k++) begin
            mask[k] = (k >= int'(ptr_q));
        end
    end

    assign req_masked = req_i & mask;

    first1_finder #(
        .W(REQ_N)
    ) u_find_masked (
        .vec_i  (req_masked),
        .oh_o   (oh_m),
        .found_o(found_m)
    );

    first1_finder #(
        .W(REQ_N)
    ) u_find_all (
        .vec_i  (req_i),
        .oh_o   (oh_u),
        .found_o(found_u)
    );

    // Masked hit wins; otherwise wrap to lowest overall.
    always_comb begin
        win_oh = '0;
        if (found_m) begin
            win_oh = oh_m;
        end else if (found_u) begin
            win_oh = oh_u;
        end
    end

    assign win_idx   = IDX_W'(onehot2idx(32'(win_oh)));
    assign owner_req = req_i[idx_q];
    assign hit_top   = TMO_EN && (cnt_q == CNT_TOP);
    assign ptr_next  = (idx_q == IDX_LAST) ?
                       '0 : idx_q + IDX_W'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            idx_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    tmo_q <= 1'b0;
                    if (|req_i) begin
                        state_q <= BUSY;
                        gnt_q   <= win_oh;
                        idx_q   <= win_idx;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                BUSY: begin
                    // Release has priority over timeout.
                    if (!owner_req) begin
                        state_q <= IDLE;
                        gnt_q   <= '0;
                        ptr_q   <= ptr_next;
                        cnt_q   <= '0;
                    end else if (hit_top) begin
                        state_q <= IDLE;
                        gnt_q   <= '0;
                        ptr_q   <= ptr_next;
                        cnt_q   <= '0;
                        tmo_q   <= 1'b1;
                    end else if (cnt_q != CNT_SAT) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign gnt_o     = gnt_q;
    assign gnt_val_o = |gnt_q;
    assign gnt_idx_o = idx_q;
    assign tmo_o     = tmo_q;

endmodule
